des_round_key_sequencer: RTL and testbench
==========================================

// Module: des_round_key_sequencer
// PURPOSE
//  Downstream of the round-key generator. Captures the complete 16-entry DES round-key set
//  in one transaction, then serves one 48-bit key per round to the iterative Feistel round
//  engine under a valid/ack handshake.
//  Encrypt order is K1..K16; decrypt order is K16..K1. The key set is held across blocks,
//  so many blocks can be processed with a single key load.
// PARAMETERS
//  KEY_W   48   width of one round key
//  ROUNDS  16   number of round keys stored and served
//  IDX_W   4    round index width; ROUNDS <= 2**IDX_W
// PORTS
//  clk            in   1              single clock, all state updates on rising edge
//  rst_n          in   1              synchronous, active-low reset
//  keyValid       in   1              keyBundle holds a new key set
//  keyBundle      in   KEY_W*ROUNDS   {K1,...,K16}; K1 at [767:720], K16 at [47:0]
//  keyReady       out  1              key set accepted when keyValid&keyReady
//  startValid     in   1              request to stream one block's keys
//  decrypt        in   1              sampled with start; 1 = reverse order
//  startReady     out  1              start accepted when startValid&startReady
//  roundKey       out  KEY_W          current round key (registered)
//  roundKeyValid  out  1              roundKey/roundIdx valid
//  roundIdx       out  IDX_W          0..ROUNDS-1, position in stream (not key number)
//  lastRound      out  1              roundKeyValid & roundIdx==ROUNDS-1
//  roundAck       in   1              engine consumed current roundKey
//  streamDone     out  1              one-cycle pulse after final ack
//  keyLoaded      out  1              a valid key set is stored
// BEHAVIOUR
//  Reset: state=EMPTY; all outputs 0, except keyReady=1. Key store is cleared; keyLoaded=0.
//  States and transitions:
//   EMPTY  -> LOADED on key accept
//   LOADED -> STREAM on start accept
//   STREAM -> LOADED after ack of roundIdx==ROUNDS-1
//  keyReady = (state!=STREAM). A key accept writes all 16 entries in 1 cycle; keyLoaded=1 next cycle.
//  In LOADED, a new key overwrites the store; next start uses the new set.
//  startReady = (state==LOADED) & ~keyValid. A key offer in the same cycle wins;
//   start stalls 1 cycle. startValid in EMPTY is ignored (no error flag).
//  Start accept at edge N:
//   - latches decrypt and sets idx=0
//   - at edge N, roundKey <= store[decrypt ? ROUNDS-1 : 0]
//   - roundKeyValid=1 from cycle N+1 (latency 1)
//  While roundKeyValid=1, roundKey and roundIdx hold stable until roundAck. roundAck with
//   roundKeyValid=0 is ignored.
//  Ack with idx<ROUNDS-1: idx++ and roundKey <= next entry, valid stays high.
//   Back-to-back acks yield 1 key per cycle; a full stream takes ROUNDS cycles minimum.
//  Ack with idx==ROUNDS-1:
//   - roundKeyValid=0 next cycle; streamDone=1 for exactly that cycle
//   - state=LOADED; startReady may assert in that same cycle
//  idx never wraps; it is reset to 0 only by start accept.
//  decrypt is ignored outside start accept; the order is fixed for the whole stream.
//  Reset mid-stream: stream abandoned; no streamDone pulse; store cleared; key must be reloaded.
// TESTING
//  1 Load Kn=48'h0000_0000_00nn (n=1..16), start decrypt=0, ack every cycle
//    -> roundKey 01,02..10 on 16 consecutive cycles; lastRound with 10; streamDone the next cycle.
//  2 Same key set, decrypt=1 -> roundKey 10,0F..01; roundIdx 0..15; startReady high after done.
//  3 Ack held low 5 cycles at idx=3 -> roundKey=04 and roundIdx=3 stable;
//    keyValid pulsed in that window -> keyReady=0 and the store is unchanged.
//  4 In LOADED, keyValid & startValid same cycle with new set Kn=48'hA0_00nn
//    -> key taken, start stalled 1 cycle, then first roundKey=48'hA0_0001.
//  5 startValid from reset -> ignored; then assert rst_n=0 at idx=7 -> all outputs 0,
//    keyLoaded=0, no streamDone, next start ignored until reload.
//  6 Two streams back-to-back (start issued in the streamDone cycle)
//    -> exactly 1 idle cycle between final key and next first key.

Source files
------------

// File: rtl/des_round_key_sequencer.sv
// rtl/des_round_key_sequencer.sv - DES round-key store that streams K1..K16 or K16..K1 to the round engine
module des_round_key_sequencer #(
    parameter int KEY_W  = 48,
    parameter int ROUNDS = 16,
    parameter int IDX_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    keyValid,
    input  logic [KEY_W*ROUNDS-1:0] keyBundle,
    output logic                    keyReady,
    input  logic                    startValid,
    input  logic                    decrypt,
    output logic                    startReady,
    output logic [KEY_W-1:0]        roundKey,
    output logic                    roundKeyValid,
    output logic [IDX_W-1:0]        roundIdx,
    output logic                    lastRound,
    input  logic                    roundAck,
    output logic                    streamDone,
    output logic                    keyLoaded
);

    typedef enum logic [1:0] {ST_EMPTY, ST_LOADED, ST_STREAM} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

    state_t           state_q, state_d;
    logic [KEY_W-1:0] store_q [ROUNDS];
    logic [KEY_W-1:0] store_d [ROUNDS];
    logic [KEY_W-1:0] round_key_q, round_key_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             decrypt_q, decrypt_d;
    logic             done_q, done_d;
    logic             loaded_q, loaded_d;

    logic             key_accept;
    logic             start_accept;
    logic             round_step;
    logic [IDX_W-1:0] next_idx;
    logic [IDX_W-1:0] fetch_idx;

    assign keyReady     = (state_q != ST_STREAM);
    // A simultaneous key offer wins over start so a stream never begins on a stale set.
    assign startReady   = (state_q == ST_LOADED) & ~keyValid;
    assign key_accept   = keyValid & keyReady;
    assign start_accept = startValid & startReady;
    assign round_step   = valid_q & roundAck;

    always_comb begin
        state_d     = state_q;
        store_d     = store_q;
        round_key_d = round_key_q;
        idx_d       = idx_q;
        valid_d     = valid_q;
        decrypt_d   = decrypt_q;
        loaded_d    = loaded_q;
        done_d      = 1'b0;
        next_idx    = idx_q + IDX_W'(1);
        fetch_idx   = '0;

        if (key_accept) begin
            for (int i = 0; i < ROUNDS; i++) begin
                store_d[i] = keyBundle[(ROUNDS-1-i)*KEY_W +: KEY_W];
            end
            loaded_d = 1'b1;
            state_d  = ST_LOADED;
        end else if (start_accept) begin
            decrypt_d   = decrypt;
            idx_d       = '0;
            fetch_idx   = decrypt ? LAST_IDX : '0;
            round_key_d = store_q[fetch_idx];
            valid_d     = 1'b1;
            state_d     = ST_STREAM;
        end else if (round_step) begin
            if (idx_q == LAST_IDX) begin
                valid_d = 1'b0;
                done_d  = 1'b1;
                state_d = ST_LOADED;
            end else begin
                idx_d       = next_idx;
                fetch_idx   = decrypt_q ? (LAST_IDX - next_idx) : next_idx;
                round_key_d = store_q[fetch_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            for (int i = 0; i < ROUNDS; i++) begin
                store_q[i] <= '0;
            end
            round_key_q <= '0;
            idx_q       <= '0;
            valid_q     <= 1'b0;
            decrypt_q   <= 1'b0;
            done_q      <= 1'b0;
            loaded_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            store_q     <= store_d;
            round_key_q <= round_key_d;
            idx_q       <= idx_d;
            valid_q     <= valid_d;
            decrypt_q   <= decrypt_d;
            done_q      <= done_d;
            loaded_q    <= loaded_d;
        end
    end

    assign roundKey      = round_key_q;
    assign roundKeyValid = valid_q;
    assign roundIdx      = idx_q;
    assign lastRound     = valid_q & (idx_q == LAST_IDX);
    assign streamDone    = done_q;
    assign keyLoaded     = loaded_q;

endmodule

// File: tb/tb_des_round_key_sequencer.sv
// tb/tb_des_round_key_sequencer.sv - bench for des_round_key_sequencer: vector table, corner sequences, random vs model
module tb_des_round_key_sequencer;

    localparam int KEY_W  = 48;
    localparam int ROUNDS = 16;
    localparam int IDX_W  = 4;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    keyValid;
    logic [KEY_W*ROUNDS-1:0] keyBundle;
    logic                    keyReady;
    logic                    startValid;
    logic                    decrypt;
    logic                    startReady;
    logic [KEY_W-1:0]        roundKey;
    logic                    roundKeyValid;
    logic [IDX_W-1:0]        roundIdx;
    logic                    lastRound;
    logic                    roundAck;
    logic                    streamDone;
    logic                    keyLoaded;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    des_round_key_sequencer #(.KEY_W(KEY_W), .ROUNDS(ROUNDS), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .keyValid(keyValid), .keyBundle(keyBundle), .keyReady(keyReady),
        .startValid(startValid), .decrypt(decrypt), .startReady(startReady),
        .roundKey(roundKey), .roundKeyValid(roundKeyValid), .roundIdx(roundIdx),
        .lastRound(lastRound), .roundAck(roundAck), .streamDone(streamDone),
        .keyLoaded(keyLoaded)
    );

    // Reference model: the stored key list plus "which position of which order is on offer".
    logic [KEY_W-1:0] tb_keys [ROUNDS];
    logic [KEY_W-1:0] m_keys  [ROUNDS];
    bit m_loaded, m_stream, m_dec, m_done;
    int m_pos;

    typedef struct {
        bit kv, sv, dec, ack;
        bit e_valid;
        logic [KEY_W-1:0] e_key;
        int e_idx;
        bit e_last, e_done, e_sready, e_loaded;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic build_bundle();
        for (int i = 0; i < ROUNDS; i++) keyBundle[(ROUNDS-1-i)*KEY_W +: KEY_W] = tb_keys[i];
    endtask

    task automatic set_keys_seq(input logic [KEY_W-1:0] base);
        for (int i = 0; i < ROUNDS; i++) tb_keys[i] = base + KEY_W'(i + 1);
        build_bundle();
    endtask

    task automatic set_keys_rand();
        for (int i = 0; i < ROUNDS; i++) tb_keys[i] = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF;
        build_bundle();
    endtask

    task automatic drive(input bit kv, input bit sv, input bit dec, input bit ack);
        keyValid = kv; startValid = sv; decrypt = dec; roundAck = ack;
    endtask

    task automatic model_update();
        m_done = 1'b0;
        if (!rst_n) begin
            m_loaded = 1'b0; m_stream = 1'b0; m_pos = 0;
            for (int i = 0; i < ROUNDS; i++) m_keys[i] = '0;
        end else if (keyValid && !m_stream) begin
            m_keys = tb_keys; m_loaded = 1'b1;
        end else if (startValid && m_loaded && !m_stream) begin
            m_stream = 1'b1; m_pos = 0; m_dec = decrypt;
        end else if (m_stream && roundAck) begin
            if (m_pos == ROUNDS - 1) begin
                m_stream = 1'b0; m_done = 1'b1;
            end else begin
                m_pos++;
            end
        end
    endtask

    task automatic model_check();
        logic [KEY_W-1:0] ek;
        check("keyReady", 64'(keyReady), 64'(!m_stream));
        check("startReady", 64'(startReady), 64'(m_loaded && !m_stream && !keyValid));
        check("roundKeyValid", 64'(roundKeyValid), 64'(m_stream));
        check("streamDone", 64'(streamDone), 64'(m_done));
        check("keyLoaded", 64'(keyLoaded), 64'(m_loaded));
        check("lastRound", 64'(lastRound), 64'(m_stream && m_pos == ROUNDS - 1));
        if (m_stream) begin
            ek = m_dec ? m_keys[ROUNDS-1-m_pos] : m_keys[m_pos];
            check("roundKey", 64'(roundKey), 64'(ek));
            check("roundIdx", 64'(roundIdx), 64'(m_pos));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic add(input bit kv, input bit sv, input bit dec, input bit ack, input bit ev,
                       input logic [KEY_W-1:0] ek, input int ei, input bit el, input bit ed,
                       input bit esr, input bit eld);
        vec_t v;
        v.kv = kv; v.sv = sv; v.dec = dec; v.ack = ack; v.e_valid = ev; v.e_key = ek;
        v.e_idx = ei; v.e_last = el; v.e_done = ed; v.e_sready = esr; v.e_loaded = eld;
        tbl.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        set_keys_seq('0);

        // Encrypt stream, decrypt stream started in the streamDone cycle, then idle.
        add(1, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, '0, 0, 0, 0, 1, 1);
        for (int n = 1; n <= ROUNDS; n++) add(0, 0, 0, 1, 1, KEY_W'(n), n - 1, n == ROUNDS, 0, 0, 1);
        add(0, 1, 1, 0, 0, '0, 0, 0, 1, 1, 1);
        for (int j = 0; j < ROUNDS; j++) add(0, 0, 0, 1, 1, KEY_W'(ROUNDS - j), j, j == ROUNDS - 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, '0, 0, 0, 1, 1, 1);
        add(0, 0, 0, 0, 0, '0, 0, 0, 0, 1, 1);

        tick(); tick();
        #4;
        check("rst_keyReady", 64'(keyReady), 64'(1));
        check("rst_startReady", 64'(startReady), 64'(0));
        check("rst_roundKeyValid", 64'(roundKeyValid), 64'(0));
        check("rst_roundKey", 64'(roundKey), 64'(0));
        check("rst_roundIdx", 64'(roundIdx), 64'(0));
        check("rst_lastRound", 64'(lastRound), 64'(0));
        check("rst_streamDone", 64'(streamDone), 64'(0));
        check("rst_keyLoaded", 64'(keyLoaded), 64'(0));
        rst_n = 1'b1;
        tick();

        foreach (tbl[k]) begin
            drive(tbl[k].kv, tbl[k].sv, tbl[k].dec, tbl[k].ack);
            #4;
            check($sformatf("vec%0d_valid", k), 64'(roundKeyValid), 64'(tbl[k].e_valid));
            check($sformatf("vec%0d_done", k), 64'(streamDone), 64'(tbl[k].e_done));
            check($sformatf("vec%0d_last", k), 64'(lastRound), 64'(tbl[k].e_last));
            check($sformatf("vec%0d_startReady", k), 64'(startReady), 64'(tbl[k].e_sready));
            check($sformatf("vec%0d_keyLoaded", k), 64'(keyLoaded), 64'(tbl[k].e_loaded));
            if (tbl[k].e_valid) begin
                check($sformatf("vec%0d_key", k), 64'(roundKey), 64'(tbl[k].e_key));
                check($sformatf("vec%0d_idx", k), 64'(roundIdx), 64'(tbl[k].e_idx));
            end
            tick();
        end

        // Ack stall at idx 3 with a key offer that must be refused.
        drive(0, 1, 0, 0); #4; model_check(); tick();
        for (int k = 0; k < 3; k++) begin drive(0, 0, 0, 1); #4; model_check(); tick(); end
        set_keys_seq(48'hBEEF_0000_0000);
        for (int k = 0; k < 5; k++) begin
            drive(k == 2, 0, 0, 0);
            #4;
            check("stall_key", 64'(roundKey), 64'(4));
            check("stall_idx", 64'(roundIdx), 64'(3));
            check("stall_keyReady", 64'(keyReady), 64'(0));
            model_check();
            tick();
        end
        for (int k = 0; k < 13; k++) begin drive(0, 0, 0, 1); #4; model_check(); tick(); end
        drive(0, 0, 0, 0); #4; model_check(); tick();

        // Key and start offered together: key wins, start follows a cycle later.
        set_keys_seq(48'hA0_0000);
        drive(1, 1, 0, 0); #4;
        check("collide_startReady", 64'(startReady), 64'(0));
        model_check(); tick();
        drive(0, 1, 0, 0); #4; model_check(); tick();
        drive(0, 0, 0, 0); #4;
        check("collide_first_key", 64'(roundKey), 64'(48'hA0_0001));
        check("collide_valid", 64'(roundKeyValid), 64'(1));
        model_check(); tick();
        for (int k = 0; k < ROUNDS; k++) begin drive(0, 0, 0, 1); #4; model_check(); tick(); end
        drive(0, 0, 0, 0); #4; model_check(); tick();

        // Start from empty is ignored; reset mid-stream abandons everything.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 0, 0); #4;
            check("empty_startReady", 64'(startReady), 64'(0));
            check("empty_valid", 64'(roundKeyValid), 64'(0));
            model_check(); tick();
        end
        set_keys_rand();
        drive(1, 0, 0, 0); #4; model_check(); tick();
        drive(0, 1, 1, 0); #4; model_check(); tick();
        for (int k = 0; k < 7; k++) begin drive(0, 0, 0, 1); #4; model_check(); tick(); end
        drive(0, 0, 0, 0); #4;
        check("pre_reset_idx", 64'(roundIdx), 64'(7));
        rst_n = 1'b0; tick(); #4;
        check("midrst_valid", 64'(roundKeyValid), 64'(0));
        check("midrst_key", 64'(roundKey), 64'(0));
        check("midrst_idx", 64'(roundIdx), 64'(0));
        check("midrst_done", 64'(streamDone), 64'(0));
        check("midrst_loaded", 64'(keyLoaded), 64'(0));
        check("midrst_keyReady", 64'(keyReady), 64'(1));
        rst_n = 1'b1; tick();
        for (int k = 0; k < 2; k++) begin
            drive(0, 1, 0, 0); #4;
            check("post_rst_done", 64'(streamDone), 64'(0));
            model_check(); tick();
        end

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            drive($urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0, 1'($urandom), 1'($urandom));
            if (keyValid) set_keys_rand();
            #4;
            model_check();
            tick();
        end

        rst_n = 1'b1;
        drive(0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
